// File: rtl/pc_fetch_unit.sv
// Program counter and fetch stage: holds the PC, slices the opcode, resolves
// B/BR conditions against the flags and freezes the core on HLT.
module pc_fetch_unit #(
  parameter int unsigned       PC_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] instr,
  input  logic            instr_valid,
  input  logic            branch_en,
  input  logic            branch,
  input  logic            hlt,
  input  logic            flag_z,
  input  logic            flag_v,
  input  logic            flag_n,
  input  logic [PC_W-1:0] reg_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus2,
  output logic [3:0]      opcode,
  output logic            taken,
  output logic            retire,
  output logic            halted
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] br_offset;
  logic            cond;

  assign pc       = pc_q;
  assign pc_plus2 = pc_q + PC_W'(2);
  assign halted   = (state_q == HALTED);

  // imm9 is a halfword offset: sign-extend then scale by two
  assign br_offset = {{(PC_W-10){instr[8]}}, instr[8:0], 1'b0};

  always_comb begin
    cond = 1'b0;
    case (instr[11:9])
      3'b000:  cond = ~flag_z;
      3'b001:  cond = flag_z;
      3'b010:  cond = ~flag_z & ~flag_n;
      3'b011:  cond = flag_n;
      3'b100:  cond = flag_z | ~flag_n;
      3'b101:  cond = flag_n | flag_z;
      3'b110:  cond = flag_v;
      default: cond = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    retire  = (state_q == RUN) & instr_valid & ~rst;
    taken   = 1'b0;
    opcode  = '0;
    if (retire) begin
      opcode = instr[PC_W-1:PC_W-4];
      // HLT takes priority over any simultaneous branch request
      if (hlt) begin
        state_d = HALTED;
      end else begin
        taken = branch_en & cond;
        if (taken && branch)
          pc_d = reg_target;
        else if (taken)
          pc_d = pc_plus2 + br_offset;
        else
          pc_d = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule
